// File: rtl/acc_param.sv
// acc_param: parameterised accumulator reducing a programmable-length run of
// unsigned samples by wrap sum, saturating sum, max or min, with a Done pulse.
module acc_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 12,
  parameter int unsigned LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  acc_out,
  output logic              overflow
);

  localparam int unsigned SUM_W = ACC_W + 1;

  localparam logic [1:0] MODE_WRAP = 2'd0;
  localparam logic [1:0] MODE_SAT  = 2'd1;
  localparam logic [1:0] MODE_MAX  = 2'd2;
  localparam logic [1:0] MODE_MIN  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [SUM_W-1:0]   sum_w;
  logic [ACC_W-1:0]   data_ext;
  logic [LEN_W-1:0]   cnt_inc;
  logic               first;

  // Datapath helpers: widened sum for carry detection, zero-extended sample
  always_comb begin
    data_ext = ACC_W'(data_in);
    sum_w    = {1'b0, acc_q} + SUM_W'(data_in);
    cnt_inc  = cnt_q + LEN_W'(1);
    first    = (cnt_q == '0);
  end

  // Next-state and next-datapath decode
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    if (state_q == S_ACCUM) begin
      // In ACCUM start is ignored; in_ready is implied by the state
      if (in_valid) begin
        cnt_d = cnt_inc;
        case (mode_q)
          MODE_WRAP: begin
            acc_d = sum_w[ACC_W-1:0];
            if (sum_w[ACC_W]) ovf_d = 1'b1;
          end
          MODE_SAT: begin
            if (sum_w[ACC_W]) begin
              acc_d = '1;
              ovf_d = 1'b1;
            end else begin
              acc_d = sum_w[ACC_W-1:0];
            end
          end
          MODE_MAX: acc_d = (first || (data_ext > acc_q)) ? data_ext : acc_q;
          MODE_MIN: acc_d = (first || (data_ext < acc_q)) ? data_ext : acc_q;
          default:  acc_d = acc_q;
        endcase
        if (cnt_inc == len_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
    end else if (start) begin
      // IDLE or DONE: begin a new run; an empty run finishes immediately
      mode_d = mode;
      len_d  = len;
      cnt_d  = '0;
      acc_d  = '0;
      ovf_d  = 1'b0;
      if (len == '0) begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = S_ACCUM;
      end
    end else begin
      state_d = S_IDLE;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 2'd0;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Output mapping: handshake/busy decode from state, the rest are registers
  always_comb begin
    in_ready = (state_q == S_ACCUM);
    busy     = (state_q == S_ACCUM);
    done     = done_q;
    acc_out  = acc_q;
    overflow = ovf_q;
  end

endmodule

// File: tb/tb_acc_param.sv
// Self-checking bench for acc_param: directed runs plus randomised runs,
// checked against an arithmetic reference of each reduction mode.
module tb_acc_param;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 10;
  localparam int unsigned LEN_W  = 4;
  localparam int          MAXV   = 1 << ACC_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [1:0]        mode;
  logic [LEN_W-1:0]  len;
  logic              in_valid;
  logic [DATA_W-1:0] data_in;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  acc_out;
  logic              overflow;

  int n_cmp  = 0;
  int n_fail = 0;
  int q[$];

  acc_param #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .len      (len),
    .in_valid (in_valid),
    .data_in  (data_in),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .acc_out  (acc_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: reduce the first k samples of a run under mode m
  task automatic model(input int m, input int s[$], input int k,
                       output int acc, output int ovf);
    int tot;
    tot = 0; acc = 0; ovf = 0;
    for (int i = 0; i < k; i++) tot += s[i];
    case (m)
      0: begin acc = tot % MAXV; ovf = (tot >= MAXV) ? 1 : 0; end
      1: begin acc = (tot > MAXV - 1) ? MAXV - 1 : tot; ovf = (tot > MAXV - 1) ? 1 : 0; end
      2: for (int i = 0; i < k; i++) if (i == 0 || s[i] > acc) acc = s[i];
      default: for (int i = 0; i < k; i++) if (i == 0 || s[i] < acc) acc = s[i];
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle: no run active, no Done
  task automatic idle_chk();
    step();
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ready", 32'(in_ready), 32'd0);
  endtask

  // gap: 0 contiguous, 1 one idle cycle before each sample, 2 random 0..2
  // Returns positioned in the Done cycle (or IDLE if extra_valid)
  task automatic run(input int m, input int s[$], input int gap,
                     input bit hold_start, input bit extra_valid);
    int n, ea, eo, g;
    n = s.size();
    ea = 0; eo = 0;
    start = 1'b1; mode = 2'(m); len = LEN_W'(n);
    in_valid = 1'b1; data_in = DATA_W'($urandom);
    step();
    in_valid = 1'b0;
    start = hold_start && (n != 0);
    if (hold_start) mode = 2'(~m);
    chk("start_acc", 32'(acc_out), 32'd0);
    chk("start_ovf", 32'(overflow), 32'd0);
    if (n == 0) begin
      chk("len0_done", 32'(done), 32'd1);
      chk("len0_busy", 32'(busy), 32'd0);
      return;
    end
    chk("start_done", 32'(done), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < n; i++) begin
      g = (gap == 0) ? 0 : (gap == 1) ? 1 : $urandom_range(0, 2);
      for (int j = 0; j < g; j++) begin
        in_valid = 1'b0; data_in = DATA_W'($urandom);
        step();
        chk("gap_done", 32'(done), 32'd0);
        chk("gap_busy", 32'(busy), 32'd1);
      end
      in_valid = 1'b1; data_in = DATA_W'(s[i]);
      step();
      in_valid = 1'b0;
      model(m, s, i + 1, ea, eo);
      chk("acc", 32'(acc_out), 32'(ea));
      chk("ovf", 32'(overflow), 32'(eo));
      if (i < n - 1) begin
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_ready", 32'(in_ready), 32'd1);
      end else begin
        chk("fin_done", 32'(done), 32'd1);
        chk("fin_ready", 32'(in_ready), 32'd0);
        chk("fin_busy", 32'(busy), 32'd0);
      end
    end
    start = 1'b0;
    if (extra_valid) begin
      in_valid = 1'b1; data_in = DATA_W'(8'hFF);
      step();
      in_valid = 1'b0;
      chk("extra_done", 32'(done), 32'd0);
      chk("extra_acc", 32'(acc_out), 32'(ea));
      chk("extra_busy", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; len = '0;
    in_valid = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_acc", 32'(acc_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd0);
    #2 rst = 1'b0;
    idle_chk();

    // Wrap sum, contiguous
    q = '{10, 20, 30, 40};
    run(0, q, 0, 1'b0, 1'b0); idle_chk();
    // Wrap with overflow, then saturate
    q = '{255, 255, 255, 255, 255};
    run(0, q, 0, 1'b0, 1'b0); idle_chk();
    run(1, q, 0, 1'b0, 1'b0); idle_chk();
    // Max then min
    q = '{7, 200, 3};
    run(2, q, 0, 1'b0, 1'b0); idle_chk();
    run(3, q, 0, 1'b0, 1'b0); idle_chk();
    // Alternate-cycle valid and a stray sample in the Done cycle
    q = '{1, 2, 3};
    run(0, q, 1, 1'b0, 1'b1); idle_chk();

    // Asynchronous reset mid-run
    start = 1'b1; mode = 2'd0; len = LEN_W'(4);
    step();
    start = 1'b0;
    in_valid = 1'b1; data_in = DATA_W'(50); step();
    data_in = DATA_W'(60); step();
    chk("pre_rst_acc", 32'(acc_out), 32'd110);
    data_in = DATA_W'(70);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_acc", 32'(acc_out), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    step();
    rst = 1'b0; in_valid = 1'b0;
    idle_chk();
    chk("post_rst_acc", 32'(acc_out), 32'd0);
    q.delete();
    run(0, q, 0, 1'b0, 1'b0); idle_chk();

    // Start held during ACCUM is ignored
    q = '{5, 6, 7};
    run(0, q, 0, 1'b1, 1'b0); idle_chk();
    // Back-to-back: overflow run, then a new run started in its Done cycle
    q = '{255, 255, 255, 255, 255};
    run(0, q, 0, 1'b0, 1'b0);
    q = '{9, 4};
    run(2, q, 0, 1'b0, 1'b0);
    q.delete();
    run(1, q, 0, 1'b0, 1'b0); idle_chk();

    // Randomised runs with random gaps and occasional back-to-back starts
    for (int r = 0; r < 24; r++) begin
      int m, n;
      m = $urandom_range(0, 3);
      n = $urandom_range(0, 15);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back($urandom_range(0, 255));
      run(m, q, 2, 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) idle_chk();
    end
    idle_chk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_param.md
Name: acc_param

Overview:
Parametrised, mode-selectable accumulator. It is the next generation of the fixed 8-bit load/accumulate/done block. It takes a programmable number of unsigned samples over a valid/ready handshake and reduces them by wrapping sum, saturating sum, max or min. It raises a one-cycle Done pulse with the result and a sticky overflow flag. It sits between a sample producer and a consumer that samples the result on Done.

Parameters:
DATA_W, 8, input sample width (unsigned)
ACC_W, 12, accumulator/result width; must be >= DATA_W
LEN_W, 4, width of the sample-count field; max run length 2^LEN_W-1

Ports:
Clk  input  1  single clock, rising edge
Reset  input  1  asynchronous, active-high; clears all state
Start  input  1  run request; accepted only in IDLE or DONE
Mode  input  2  latched on Start: 00 wrap sum, 01 saturating sum, 10 max, 11 min
Len  input  LEN_W  latched on Start: number of samples in the run
In_Valid  input  1  Data_In is valid this cycle
Data_In  input  DATA_W  sample
In_Ready  output  1  block accepts a sample this cycle
Busy  output  1  high while in ACCUM
Done  output  1  one-cycle pulse when the result is final
Acc_Out  output  ACC_W  running/final result
Overflow  output  1  sticky for the current run

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (Clk, Reset). On Reset: state=IDLE, Acc_Out=0, Done=0, Overflow=0, In_Ready=0, Busy=0, sample counter=0.
- FSM states: IDLE, ACCUM, DONE. All outputs are registered except In_Ready and Busy, which decode from state (both high only in ACCUM).
- IDLE/DONE, Start=1 at an edge:
  - latch Mode and Len;
  - clear Acc_Out to 0, Overflow to 0, counter to 0;
  - go to ACCUM, or to DONE if Len==0 (Done pulses next cycle with Acc_Out=0).
- ACCUM, Start is ignored.
- Accept: a sample is accepted at an edge where In_Valid & In_Ready. Gaps in In_Valid are allowed. On each accept the counter increments and Acc_Out updates, visible the next cycle.
  - 00: Acc_Out = (Acc_Out + zero-extended Data_In) mod 2^ACC_W. Overflow set on carry out.
  - 01: same sum but clamped to 2^ACC_W-1. Overflow set when the clamp engages.
  - 10: first accepted sample loads directly; afterwards Acc_Out = max(Acc_Out, Data_In).
  - 11: first accepted sample loads directly; afterwards Acc_Out = min(Acc_Out, Data_In).
  - Overflow stays 0 in modes 10 and 11.
- The edge that accepts the Len-th sample moves the state to DONE. In that following cycle Done=1 and Acc_Out is final; In_Ready=0, so no extra samples are taken.
- DONE lasts exactly one cycle, then goes to IDLE unless Start=1 (back-to-back run, Done still pulses once). Acc_Out and Overflow hold in IDLE until the next accepted Start.
- Counter width is LEN_W. It never wraps, because the run ends when counter==Len.
- Reset mid-run: immediate return to IDLE with all outputs 0; the partial result is discarded.
- Start and In_Valid in the same cycle in IDLE: Start is taken; the sample is not accepted (In_Ready=0).

Test Plan:
1. ACC_W=10, Mode=00, Len=4, contiguous samples 10,20,30,40 -> Done pulses one cycle after the 4th accept, Acc_Out=100, Overflow=0.
2. ACC_W=10, Mode=00, Len=5, five samples of 255 -> Acc_Out=251 (1275 mod 1024), Overflow=1. Repeat with Mode=01 -> Acc_Out=1023, Overflow=1.
3. Mode=10 then Mode=11, Len=3, samples 7,200,3 -> Acc_Out=200, then Acc_Out=3; Overflow=0 for both.
4. Mode=00, Len=3, In_Valid high on alternate cycles with samples 1,2,3 -> only valid cycles accepted, Acc_Out=6, single Done pulse. Extra In_Valid during DONE is ignored.
5. Mode=00, Len=4, assert Reset asynchronously after 2 accepts -> Acc_Out=0, Busy=0, In_Ready=0 immediately. Then Start with Len=0 -> Done the next cycle with Acc_Out=0.
6. Start held during ACCUM -> ignored. Start asserted in the DONE cycle -> new run begins, Acc_Out and Overflow cleared, exactly one Done per run.
